// File: rtl/alu_pkg.sv
// Shared decode types for the ALU decoder: ALU op select, RV32I opcodes, funct7 values.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SRL   = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_AND   = 4'd5,
        ALU_OR    = 4'd6,
        ALU_SLT   = 4'd7,
        ALU_SLTU  = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/imm_gen.sv
// Combinational I/S/U immediate extraction for RV32I.
module imm_gen (
    input  logic [31:0] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_u
);
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u = {instr[31:12], 12'b0};
endmodule

// File: rtl/alu_decoder.sv
// RV32I ALU decoder with a single registered valid/ready output stage.
// Optional saturating illegal-instruction counter: define ALU_DECODER_ILLEGAL_CNT_EN.
import alu_pkg::*;

module alu_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_rs1_data,
    input  logic [31:0]      i_rs2_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_rs1_data,
    output logic [31:0]      o_rs2_data,
    output logic [3:0]       o_alu_sel,
    output logic [4:0]       o_rd,
    output logic             o_wb_en,
    output logic             o_illegal
`ifdef ALU_DECODER_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0] o_illegal_cnt
`endif
);

    logic [31:0] imm_i, imm_s, imm_u;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] shamt_r, shamt_i;
    logic        accept;

    alu_sel_e    d_sel;
    logic [31:0] d_a, d_b;
    logic [4:0]  d_rd;
    logic        d_wb, d_ill;

    imm_gen u_imm_gen (
        .instr (i_instr),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_u (imm_u)
    );

    assign opc     = i_instr[6:0];
    assign f3      = i_instr[14:12];
    assign f7      = i_instr[31:25];
    assign shamt_r = {27'b0, i_rs2_data[4:0]};
    assign shamt_i = {27'b0, i_instr[24:20]};

    // Stage can take a new bundle when empty or when the current one drains this cycle.
    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;

    // Decode the incoming instruction; illegal encodings collapse to a zeroed ADD bundle.
    always_comb begin
        d_sel = ALU_ADD;
        d_a   = '0;
        d_b   = '0;
        d_rd  = i_instr[11:7];
        d_wb  = 1'b0;
        d_ill = 1'b0;
        case (opc)
            OPC_OP: begin
                d_a  = i_rs1_data;
                d_b  = i_rs2_data;
                d_wb = 1'b1;
                if (f7 == F7_ZERO) begin
                    case (f3)
                        3'b000: d_sel = ALU_ADD;
                        3'b001: begin d_sel = ALU_SLL; d_b = shamt_r; end
                        3'b010: d_sel = ALU_SLT;
                        3'b011: d_sel = ALU_SLTU;
                        3'b100: d_sel = ALU_XOR;
                        3'b101: begin d_sel = ALU_SRL; d_b = shamt_r; end
                        3'b110: d_sel = ALU_OR;
                        default: d_sel = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    d_sel = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    d_sel = ALU_SRA;
                    d_b   = shamt_r;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                d_a  = i_rs1_data;
                d_b  = imm_i;
                d_wb = 1'b1;
                case (f3)
                    3'b000: d_sel = ALU_ADD;
                    3'b010: d_sel = ALU_SLT;
                    3'b011: d_sel = ALU_SLTU;
                    3'b100: d_sel = ALU_XOR;
                    3'b110: d_sel = ALU_OR;
                    3'b111: d_sel = ALU_AND;
                    3'b001: begin
                        d_sel = ALU_SLL;
                        d_b   = shamt_i;
                        d_ill = (f7 != F7_ZERO);
                    end
                    default: begin
                        d_b = shamt_i;
                        if (f7 == F7_ZERO)     d_sel = ALU_SRL;
                        else if (f7 == F7_ALT) d_sel = ALU_SRA;
                        else                   d_ill = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                d_sel = ALU_PASSB;
                d_b   = imm_u;
                d_wb  = 1'b1;
            end
            OPC_AUIPC: begin
                d_a  = i_pc;
                d_b  = imm_u;
                d_wb = 1'b1;
            end
            OPC_LOAD: begin
                d_a  = i_rs1_data;
                d_b  = imm_i;
                d_wb = 1'b1;
            end
            OPC_STORE: begin
                // rd field carries immediate bits for stores; no destination.
                d_a  = i_rs1_data;
                d_b  = imm_s;
                d_rd = '0;
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_sel = ALU_ADD;
            d_a   = '0;
            d_b   = '0;
            d_rd  = '0;
            d_wb  = 1'b0;
        end
        if (d_rd == 5'd0) d_wb = 1'b0;
    end

    // Output register: load on accept, drop valid on drain, hold while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_alu_sel  <= '0;
            o_rs1_data <= '0;
            o_rs2_data <= '0;
            o_rd       <= '0;
            o_wb_en    <= 1'b0;
            o_illegal  <= 1'b0;
        end else if (accept) begin
            o_valid    <= 1'b1;
            o_alu_sel  <= d_sel;
            o_rs1_data <= d_a;
            o_rs2_data <= d_b;
            o_rd       <= d_rd;
            o_wb_en    <= d_wb;
            o_illegal  <= d_ill;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef ALU_DECODER_ILLEGAL_CNT_EN
    // Saturating count of accepted illegal instructions.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_illegal_cnt <= '0;
        else if (accept && d_ill && o_illegal_cnt != {CNT_W{1'b1}})
            o_illegal_cnt <= o_illegal_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// Directed self-checking bench for alu_decoder (counter checks when ALU_DECODER_ILLEGAL_CNT_EN is defined).
module tb_alu_decoder;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_ready;
    logic [31:0] i_instr, i_pc, i_rs1_data, i_rs2_data;
    logic        o_ready, o_valid, o_wb_en, o_illegal;
    logic [31:0] o_rs1_data, o_rs2_data;
    logic [3:0]  o_alu_sel;
    logic [4:0]  o_rd;
    int          checks = 0;
    int          failures = 0;

`ifdef ALU_DECODER_ILLEGAL_CNT_EN
    logic [15:0] o_illegal_cnt;
    logic        s_ready, s_valid, s_wb_en, s_illegal;
    logic [31:0] s_rs1, s_rs2;
    logic [3:0]  s_sel;
    logic [4:0]  s_rd;
    logic [1:0]  s_cnt;
`endif

    alu_decoder u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .o_alu_sel(o_alu_sel), .o_rd(o_rd), .o_wb_en(o_wb_en), .o_illegal(o_illegal)
`ifdef ALU_DECODER_ILLEGAL_CNT_EN
        , .o_illegal_cnt(o_illegal_cnt)
`endif
    );

`ifdef ALU_DECODER_ILLEGAL_CNT_EN
    // Narrow-counter instance sharing the same stimulus, to observe saturation.
    alu_decoder #(.CNT_W(2)) u_dut_sat (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(s_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .o_valid(s_valid), .i_ready(i_ready), .o_rs1_data(s_rs1), .o_rs2_data(s_rs2),
        .o_alu_sel(s_sel), .o_rd(s_rd), .o_wb_en(s_wb_en), .o_illegal(s_illegal),
        .o_illegal_cnt(s_cnt)
    );
`endif

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string t, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic wb,
                           input logic ill);
        chk({t, ".valid"}, 32'(o_valid), 32'd1);
        chk({t, ".sel"},   32'(o_alu_sel), 32'(sel));
        chk({t, ".a"},     o_rs1_data, a);
        chk({t, ".b"},     o_rs2_data, b);
        chk({t, ".rd"},    32'(o_rd), 32'(rd));
        chk({t, ".wb"},    32'(o_wb_en), 32'(wb));
        chk({t, ".ill"},   32'(o_illegal), 32'(ill));
    endtask

    // Present one instruction with i_ready=1; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
        @(negedge i_clk);
        i_instr = ins; i_pc = pc; i_rs1_data = r1; i_rs2_data = r2;
        i_valid = 1'b1; i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_instr = '0; i_pc = '0; i_rs1_data = '0; i_rs2_data = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst.valid", 32'(o_valid), 0);
        chk("rst.sel", 32'(o_alu_sel), 0);
        chk("rst.a", o_rs1_data, 0);
        chk("rst.b", o_rs2_data, 0);
        chk("rst.rd", 32'(o_rd), 0);
        chk("rst.wb", 32'(o_wb_en), 0);
        chk("rst.ill", 32'(o_illegal), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        chk("rel.ready", 32'(o_ready), 1);

        // ADD x3,x1,x2
        send(32'h002081B3, 32'h0, 32'd5, 32'd7);
        chk_out("add", 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        // SRA x5,x1,x2 : shift amount masked to rs2[4:0]
        send(32'h4020D2B3, 32'h0, 32'h80000000, 32'hFFFFFF21);
        chk_out("sra", 4'd9, 32'h80000000, 32'h1, 5'd5, 1'b1, 1'b0);
        // SRAI x6,x1,31
        send(32'h41F0D313, 32'h0, 32'h1234, 32'h0);
        chk_out("srai", 4'd9, 32'h1234, 32'd31, 5'd6, 1'b1, 1'b0);
        // AUIPC x8,0x12345 at pc 0x100
        send(32'h12345417, 32'h100, 32'hDEAD, 32'hBEEF);
        chk_out("auipc", 4'd0, 32'h100, 32'h12345000, 5'd8, 1'b1, 1'b0);
        // LUI x9,0xABCDE
        send(32'hABCDE4B7, 32'h0, 32'h55, 32'h66);
        chk_out("lui", 4'd10, 32'h0, 32'hABCDE000, 5'd9, 1'b1, 1'b0);
        // SUB x0,x1,x2 : rd=0 suppresses write-back
        send(32'h40208033, 32'h0, 32'd9, 32'd4);
        chk_out("sub_x0", 4'd1, 32'd9, 32'd4, 5'd0, 1'b0, 1'b0);
        // SW x2,8(x1)
        send(32'h0020A423, 32'h0, 32'h1000, 32'h77);
        chk_out("sw", 4'd0, 32'h1000, 32'd8, 5'd0, 1'b0, 1'b0);
        // LW x4,-4(x1)
        send(32'hFFC0A203, 32'h0, 32'h2000, 32'h0);
        chk_out("lw", 4'd0, 32'h2000, 32'hFFFFFFFC, 5'd4, 1'b1, 1'b0);
        // OP with funct7 0100000 / funct3 001 is not a valid encoding
        send(32'h40209033, 32'h0, 32'd1, 32'd2);
        chk_out("op_bad", 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        // SLLI with funct7 0100000 is illegal
        send(32'h40109093, 32'h0, 32'd1, 32'd2);
        chk_out("slli_bad", 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);

        // ADDI x7,x1,-1 then stall with a new instruction waiting
        send(32'hFFF08393, 32'h0, 32'd10, 32'h0);
        chk_out("addi", 4'd0, 32'd10, 32'hFFFFFFFF, 5'd7, 1'b1, 1'b0);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_instr = 32'h002081B3; i_rs1_data = 32'd1; i_rs2_data = 32'd2;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            chk("stall.ready", 32'(o_ready), 0);
            chk("stall.valid", 32'(o_valid), 1);
            chk("stall.b", o_rs2_data, 32'hFFFFFFFF);
            chk("stall.rd", 32'(o_rd), 7);
        end

        // Reset while stalled drops the held bundle
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk("rst2.valid", 32'(o_valid), 0);
        chk("rst2.sel", 32'(o_alu_sel), 0);
        chk("rst2.a", o_rs1_data, 0);
        chk("rst2.b", o_rs2_data, 0);
        chk("rst2.rd", 32'(o_rd), 0);
        chk("rst2.wb", 32'(o_wb_en), 0);
        @(negedge i_clk);
        i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("rel2.ready", 32'(o_ready), 1);
        chk("rel2.valid", 32'(o_valid), 0);
`ifdef ALU_DECODER_ILLEGAL_CNT_EN
        chk("rst2.cnt", 32'(o_illegal_cnt), 0);
`endif

        // Three back-to-back SYSTEM opcodes (unsupported)
        for (int k = 0; k < 3; k++) begin
            send(32'h00000073, 32'h0, 32'd3, 32'd4);
            chk_out("sys", 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        end
`ifdef ALU_DECODER_ILLEGAL_CNT_EN
        chk("cnt3", 32'(o_illegal_cnt), 3);
        chk("sat_cnt3", 32'(s_cnt), 3);
        send(32'h00000073, 32'h0, 32'd0, 32'd0);
        chk("cnt4", 32'(o_illegal_cnt), 4);
        chk("sat_hold", 32'(s_cnt), 3);
`endif
        // Drain: no accept, i_ready=1 clears valid
        @(posedge i_clk);
        #1;
        chk("drain.valid", 32'(o_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_decoder.md
ALU_DECODER -- requirements
Module: alu_decoder

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: i_clk  input  1  clock, rising edge; i_rst  input  1  synchronous active-high reset.
REQ-002 Parameter CNT_W SHALL be: CNT_W, 16, width of illegal-instruction counter.
REQ-003 i_valid  input  1  upstream instruction valid.
REQ-004 o_ready  output  1  block can accept an instruction this cycle.
REQ-005 i_instr  input  32  RV32I instruction word.
REQ-006 i_pc  input  32  PC of i_instr.
REQ-007 i_rs1_data, i_rs2_data  input  32 each  register-file read data.
REQ-008 o_valid  output  1  decoded bundle valid.
REQ-009 i_ready  input  1  downstream (ALU stage) accepts bundle.
REQ-010 o_rs1_data, o_rs2_data  output  32 each  ALU operands A and B.
REQ-011 o_alu_sel  output  4  ALU op code: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 XOR, 5 AND, 6 OR, 7 SLT, 8 SLTU, 9 SRA, 10 pass-B.
REQ-012 o_rd  output  5  destination register; o_wb_en  output  1  register write enable; o_illegal  output  1  instruction not supported.
REQ-013 o_illegal_cnt  output  CNT_W  illegal count (present only with macro, see REQ-030).

Function
REQ-014 Single registered output stage; latency = 1 cycle from accepted input to o_valid.
REQ-015 o_ready SHALL equal !o_valid || i_ready (combinational; full throughput, one bundle per cycle).
REQ-016 Input accepted when i_valid && o_ready; output register loads decoded bundle, o_valid <= 1.
REQ-017 Output consumed when o_valid && i_ready with no new accept: o_valid <= 0; accept and consume same cycle: register reloads, o_valid stays 1.
REQ-018 While o_valid && !i_ready, all outputs SHALL hold stable.
REQ-019 OP (0110011): A=rs1, B=rs2; funct7 0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3; funct7 0100000 valid only for funct3 000 (SUB) and 101 (SRA); shifts SHALL drive B={27'b0, rs2[4:0]}.
REQ-020 OP-IMM (0010011): A=rs1, B=sign-extended I-imm; SLLI/SRLI/SRAI B={27'b0, shamt}; funct7 other than 0000000 (0100000 for SRAI) is illegal.
REQ-021 LUI: sel=10, B={imm[31:12],12'b0}, A=0; AUIPC: sel=ADD, A=pc, B=U-imm.
REQ-022 LOAD: sel=ADD, A=rs1, B=I-imm, wb_en=1; STORE: sel=ADD, A=rs1, B=S-imm, wb_en=0.
REQ-023 Any other opcode/funct combination: o_illegal=1, sel=ADD, A=B=0, wb_en=0; bundle still emitted with o_valid.
REQ-024 o_wb_en SHALL be 0 when rd=0.

Reset
REQ-025 On i_rst: o_valid=0, o_alu_sel=0, operands=0, o_rd=0, o_wb_en=0, o_illegal=0, counter=0.
REQ-026 Reset mid-stall SHALL drop the held bundle; no input accepted in reset cycle.
REQ-027 o_ready SHALL be 1 in the cycle after reset release.

Configuration
REQ-028 Macro ALU_DECODER_ILLEGAL_CNT_EN controls the illegal counter.
REQ-029 Defined: counter increments by 1 per accepted illegal instruction, saturates at 2^CNT_W-1.
REQ-030 Undefined: counter and o_illegal_cnt port absent; all other behaviour identical.

Structure
REQ-031 Shared package alu_pkg SHALL hold alu_sel enum (values per REQ-011), opcode constants, funct7 constants.
REQ-032 Sub-module imm_gen (combinational I/S/U immediate extraction) SHALL be instantiated once.

Verification
REQ-033 ADD x3,x1,x2 with rs1=5, rs2=7, i_ready=1 -> next cycle o_valid=1, sel=0, A=5, B=7, rd=3, wb_en=1.
REQ-034 SRA rs2=0xFFFFFF21 -> sel=9, B=0x00000001; SRAI shamt 31 -> B=31, sel=9.
REQ-035 ADDI imm=-1, then i_ready=0 for 3 cycles -> B=0xFFFFFFFF held stable, o_ready=0, no new accept.
REQ-036 AUIPC imm=0x12345, pc=0x100 -> sel=0, A=0x100, B=0x12345000.
REQ-037 Opcode 1110011, macro defined, 3 back-to-back -> o_illegal=1, wb_en=0, counter=3; saturation with CNT_W=2 stays at 3.
REQ-038 i_rst asserted while o_valid=1, i_ready=0 -> next cycle o_valid=0, all outputs 0.
